pam_mixer_mpam: RTL and testbench
=================================

Name: pam_mixer_mpam

Overview:
Parametrised M-PAM baseband-to-carrier mixer, the successor to the fixed 4-level pam_mixer. It accepts symbols over a valid/ready handshake and buffers one symbol ahead. Each symbol is held for SPS carrier samples, mapped to a symmetric odd-integer amplitude level and multiplied by the external sin_in sample from the sin_cos generator. The output feeds the PAM demodulator chain, with a symbol-boundary strobe for demodulator alignment and an underflow indication.

Parameters:
BITS_PER_SYM, 2, bits per symbol; M = 2**BITS_PER_SYM levels (legal 1..4)
SAMPLE_W, 8, signed width of sin_in
SPS, 1000, carrier samples per symbol (legal >= 2)
OUT_W, SAMPLE_W+BITS_PER_SYM+1, signed width of signal_out

Ports:
clk  input  1  sample clock; same clock drives sin_cos
rst  input  1  asynchronous, active-low reset
enable  input  1  global run gate; when low, all state holds and out_valid=0
data_in  input  BITS_PER_SYM  symbol value
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a symbol this cycle
sin_in  input  SAMPLE_W  signed carrier sample
signal_out  output  OUT_W  signed mixed sample, registered
out_valid  output  1  signal_out carries a modulated sample
sym_start  output  1  one-cycle pulse, aligned with the first output sample of each symbol
underflow  output  1  one-cycle pulse when a symbol ends and no next symbol is available

Behaviour:
- Reset (rst=0, async): state=IDLE, sample counter=0, next buffer empty, signal_out=0, out_valid=0, sym_start=0, underflow=0, data_ready=1 once released.
- Accept: a symbol transfers when data_valid && data_ready && enable. data_ready = !next_full. It is independent of data_valid.
- Level mapping: level = 2*idx - (M-1), signed BITS_PER_SYM+1 bits. Without the optional feature, idx = data_in. For M=4: 0->-3, 1->-1, 2->+1, 3->+3.
- FSM IDLE:
  - signal_out is driven to 0 and out_valid=0.
  - A symbol accepted in IDLE loads cur_sym directly, bypassing the buffer, clears the counter and moves to RUN.
- FSM RUN, every enabled cycle:
  - signal_out <= level(cur_sym) * sin_in (full-precision signed product, no saturation).
  - out_valid <= 1.
  - The counter increments.
- Symbol boundary (RUN, counter==SPS-1):
  - The counter wraps to 0.
  - If next_full: cur_sym <= next buffer and the buffer empties.
  - Else, if a symbol is accepted in the same cycle: cur_sym loads it directly (bypass) and there is no underflow.
  - Else: underflow pulses next cycle and state returns to IDLE.
- A symbol accepted while next is empty and no boundary is occurring fills next. With next full, data_ready=0.
- sym_start is registered and asserts together with out_valid on the first sample of each symbol.
- Latency: symbol accepted at edge t -> first valid signal_out at edge t+1 (uses sin_in sampled at t+1) -> SPS valid samples per symbol.
- enable=0 in any state: counter, FSM and buffer freeze; out_valid=0; signal_out holds its value; no accept occurs.
- Reset mid-symbol: all state is discarded immediately and the buffered symbol is lost.

Optional Feature:
GRAY_MAP_EN
- Defined: idx = Gray-to-binary(data_in), so adjacent levels differ in one bit. For M=4: 00->-3, 01->-1, 11->+1, 10->+3.
- Undefined: natural binary mapping as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Package pam_pkg: state enum (IDLE, RUN); function level_of(idx, bits); function gray2bin.
- The same package is shared with the demodulator for its slicer thresholds.
- One sub-module, pam_level_map: combinational symbol -> signed level, containing the GRAY_MAP_EN switch.
- Counter, FSM, buffer and multiplier live in the top module.

Test Plan:
1. Reset held low 100 cycles, then released with data_valid=0 -> out_valid=0, signal_out=0, data_ready=1, no underflow.
2. SPS=4, sin_in constant +100, symbol 3 then 0 presented back-to-back -> outputs +300 x4, then -300 x4. sym_start fires on the 1st and 5th sample. underflow fires once after the 8th sample, then out_valid=0.
3. Stream 0,1,2,3 with data_valid held high -> data_ready drops after the buffer fills. Exactly SPS samples per symbol at levels -3,-1,+1,+3. No underflow until the stream ends.
4. Symbol presented exactly on the boundary cycle with the buffer empty -> bypass load, no underflow, no gap in out_valid.
5. enable low for 3 cycles mid-symbol -> counter frozen, out_valid=0 for 3 cycles, symbol still yields SPS total valid samples. Also assert rst mid-symbol -> outputs return to 0 asynchronously.
6. GRAY_MAP_EN build, sin_in=-128, data_in=2'b10 -> signal_out=-384. Without the macro, the same stimulus gives -128.

Source files
------------

// File: rtl/pam_pkg.sv
// pam_pkg: shared M-PAM definitions (FSM states, odd-integer level and Gray decode helpers for up to 4 bits/symbol)
package pam_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction
  function automatic logic signed [4:0] level_of(input logic [3:0] idx, input int bits);
    int v;
    v = 2 * int'(idx) - ((1 << bits) - 1);
    return v[4:0];
  endfunction
endpackage

// File: rtl/pam_level_map.sv
// pam_level_map: symbol -> signed odd level; ports sym (in), level (out); GRAY_MAP_EN selects Gray decode of sym
module pam_level_map
  import pam_pkg::*;
#(
  parameter int BITS_PER_SYM = 2
) (
  input  logic        [BITS_PER_SYM-1:0] sym,
  output logic signed [BITS_PER_SYM:0]   level
);
  logic [3:0] idx;
`ifdef GRAY_MAP_EN
  assign idx = gray2bin(4'(sym));
`else
  assign idx = 4'(sym);
`endif
  assign level = (BITS_PER_SYM + 1)'(level_of(idx, BITS_PER_SYM));
endmodule

// File: rtl/pam_mixer_mpam.sv
// pam_mixer_mpam: M-PAM mixer; ports clk, rst (async active-low), enable, data_in/data_valid/data_ready, sin_in -> signal_out, out_valid, sym_start, underflow; GRAY_MAP_EN via pam_level_map
module pam_mixer_mpam
  import pam_pkg::*;
#(
  parameter int BITS_PER_SYM = 2,
  parameter int SAMPLE_W     = 8,
  parameter int SPS          = 1000,
  parameter int OUT_W        = SAMPLE_W + BITS_PER_SYM + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [BITS_PER_SYM-1:0]    data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic signed [SAMPLE_W-1:0] sin_in,
  output logic signed [OUT_W-1:0]    signal_out,
  output logic                       out_valid,
  output logic                       sym_start,
  output logic                       underflow
);
  localparam int CW = $clog2(SPS);
  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [BITS_PER_SYM-1:0]   cur_sym, next_sym;
  logic                      next_full;
  logic signed [BITS_PER_SYM:0] level;
  logic                      accept, last;
  assign data_ready = !next_full;
  assign accept     = data_valid && data_ready && enable;
  assign last       = cnt == CW'(SPS - 1);
  pam_level_map #(.BITS_PER_SYM(BITS_PER_SYM)) u_map (.sym(cur_sym), .level(level));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_sym    <= '0;
      next_sym   <= '0;
      next_full  <= 1'b0;
      signal_out <= '0;
      out_valid  <= 1'b0;
      sym_start  <= 1'b0;
      underflow  <= 1'b0;
    end else if (!enable) begin
      out_valid <= 1'b0;
      sym_start <= 1'b0;
      underflow <= 1'b0;
    end else if (state == IDLE) begin
      signal_out <= '0;
      out_valid  <= 1'b0;
      sym_start  <= 1'b0;
      underflow  <= 1'b0;
      if (accept) begin
        cur_sym <= data_in;
        cnt     <= '0;
        state   <= RUN;
      end
    end else begin
      signal_out <= level * sin_in;
      out_valid  <= 1'b1;
      sym_start  <= cnt == '0;
      underflow  <= 1'b0;
      if (last) begin
        cnt <= '0;
        if (next_full) begin
          cur_sym   <= next_sym;
          next_full <= 1'b0;
        end else if (accept) cur_sym <= data_in;
        else begin
          underflow <= 1'b1;
          state     <= IDLE;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (accept) begin
          next_sym  <= data_in;
          next_full <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_pam_mixer_mpam.sv
// tb_pam_mixer_mpam: directed self-checking bench for pam_mixer_mpam with SPS=4
module tb_pam_mixer_mpam;
  localparam int SPS = 4;
  logic              clk = 1'b0;
  logic              rst, enable, data_valid, data_ready;
  logic [1:0]        data_in;
  logic signed [7:0] sin_in;
  logic signed [10:0] signal_out;
  logic              out_valid, sym_start, underflow;
  int n_cmp = 0, n_bad = 0;
  int lv[4];
  logic [1:0] stream[4];
  pam_mixer_mpam #(.BITS_PER_SYM(2), .SAMPLE_W(8), .SPS(SPS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .sin_in(sin_in), .signal_out(signal_out),
    .out_valid(out_valid), .sym_start(sym_start), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic samp(input int exp, input bit ss, input bit uf);
    tick;
    chk("out_valid", out_valid, 1);
    chk("signal_out", signal_out, exp);
    chk("sym_start", sym_start, ss);
    chk("underflow", underflow, uf);
  endtask
  task automatic expect_sym(input int exp, input bit uf);
    for (int i = 0; i < SPS; i++) samp(exp, i == 0, uf && i == SPS - 1);
  endtask
  task automatic feed;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      data_valid = 1'b1;
      data_in    = stream[k];
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        ok = data_ready && enable;
        tick;
      end
      if (!ok) chk("feed_timeout", 0, 1);
    end
    data_valid = 1'b0;
  endtask
  initial begin
`ifdef GRAY_MAP_EN
    lv = '{-3, -1, 3, 1};
`else
    lv = '{-3, -1, 1, 3};
`endif
    stream = '{2'd0, 2'd1, 2'd2, 2'd3};
    rst = 1'b0; enable = 1'b1; data_valid = 1'b0; data_in = '0; sin_in = 8'sd100;
    repeat (100) tick;
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b1;
    tick;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_signal_out", signal_out, 0);
    chk("idle_data_ready", data_ready, 1);
    chk("idle_underflow", underflow, 0);
    // back-to-back symbols 3 then 0
    data_valid = 1'b1; data_in = 2'd3;
    tick;
    data_in = 2'd0;
    samp(lv[3] * 100, 1, 0);
    data_valid = 1'b0;
    chk("buf_full_ready", data_ready, 0);
    for (int i = 1; i < SPS; i++) samp(lv[3] * 100, 0, 0);
    expect_sym(lv[0] * 100, 1);
    tick;
    chk("post_uf_valid", out_valid, 0);
    chk("post_uf_pulse", underflow, 0);
    // continuous stream 0,1,2,3
    fork
      feed;
      begin
        tick;
        chk("stream_first_valid", out_valid, 0);
        for (int s = 0; s < 4; s++) expect_sym(lv[s] * 100, s == 3);
      end
    join
    tick;
    chk("stream_end_valid", out_valid, 0);
    // symbol offered exactly on the boundary cycle with empty buffer
    data_valid = 1'b1; data_in = 2'd2;
    tick;
    data_valid = 1'b0;
    for (int i = 0; i < SPS - 1; i++) samp(lv[2] * 100, i == 0, 0);
    data_valid = 1'b1; data_in = 2'd1;
    samp(lv[2] * 100, 0, 0);
    data_valid = 1'b0;
    expect_sym(lv[1] * 100, 1);
    tick;
    // enable freeze mid-symbol
    data_valid = 1'b1; data_in = 2'd3;
    tick;
    data_valid = 1'b0;
    samp(lv[3] * 100, 1, 0);
    samp(lv[3] * 100, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("frz_out_valid", out_valid, 0);
      chk("frz_hold", signal_out, lv[3] * 100);
    end
    enable = 1'b1;
    samp(lv[3] * 100, 0, 0);
    samp(lv[3] * 100, 0, 1);
    tick;
    // async reset mid-symbol with a buffered symbol
    data_valid = 1'b1; data_in = 2'd0;
    tick;
    data_in = 2'd3;
    samp(lv[0] * 100, 1, 0);
    data_valid = 1'b0;
    chk("pre_rst_ready", data_ready, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_signal_out", signal_out, 0);
    chk("async_ready", data_ready, 1);
    tick;
    rst = 1'b1;
    tick;
    chk("lost_buf_valid", out_valid, 0);
    tick;
    chk("lost_buf_valid2", out_valid, 0);
    // most negative carrier sample with symbol 2'b10
    sin_in = -8'sd128;
    data_valid = 1'b1; data_in = 2'b10;
    tick;
    data_valid = 1'b0;
`ifdef GRAY_MAP_EN
    expect_sym(-384, 1);
`else
    expect_sym(-128, 1);
`endif
    tick;
    chk("final_valid", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
